// File: rtl/lqb_pkg.sv
// Shared keypad/display constants and key-index helpers.
package lqb_pkg;

    localparam logic [15:0] TICK_MAX_1MS = 16'd49_999;
    localparam logic [3:0]  KEY_NONE     = 4'd0;

    // ORing indices gives the set-bit position when exactly one bit is set.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = idx | (vec[i] ? 4'(i) : 4'd0);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [15:0] vec);
        return (vec != 16'd0) && ((vec & (vec - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_MAX+1 clocks.
module tick_gen
    import lqb_pkg::*;
#(
    parameter logic [15:0] TICK_MAX = TICK_MAX_1MS
) (
    input  logic sclk,
    input  logic nrst,
    output logic tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Wrap the counter at its terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == TICK_MAX) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TICK_MAX);

endmodule

// File: rtl/matkey_scan.sv
// 4x4 keypad scanner: column drive, frame capture, whole-frame debounce,
// single-key press events.
module matkey_scan
    import lqb_pkg::*;
#(
    parameter logic [15:0] TICK_MAX   = TICK_MAX_1MS,
    parameter logic [3:0]  DEB_FRAMES = 4'd4
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    logic        tick_s;
    logic [3:0]  row_meta_q, row_sync_q;
    logic [1:0]  col_idx_q;
    logic [15:0] snap_q, frame_q, prev_q, deb_q, deb_old_q;
    logic        frame_ld_q, eval_q, upd_q;
    logic [3:0]  stable_q, stable_d;
    logic        accept_s;
    logic [3:0]  key_code_q;
    logic        key_valid_q, key_down_q;

    tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
        .sclk (sclk),
        .nrst (nrst),
        .tick (tick_s)
    );

    // Rows idle high; the synchronizer resets to the no-key level.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Sample the driven column at the end of its dwell, then move on.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            col_idx_q  <= 2'd0;
            snap_q     <= 16'd0;
            frame_ld_q <= 1'b0;
        end else begin
            frame_ld_q <= tick_s && (col_idx_q == 2'd3);
            if (tick_s) begin
                for (int r = 0; r < 4; r++) begin
                    snap_q[{r[1:0], col_idx_q}] <= ~row_sync_q[r];
                end
                col_idx_q <= col_idx_q + 2'd1;
            end
        end
    end

    assign col_out = ~(4'b0001 << col_idx_q);

    // Count consecutive identical frames, saturating at the threshold.
    always_comb begin
        stable_d = stable_q;
        if (frame_q == prev_q) begin
            if (stable_q == DEB_FRAMES) begin
                stable_d = stable_q;
            end else begin
                stable_d = stable_q + 4'd1;
            end
        end else begin
            stable_d = 4'd0;
        end
        accept_s = (stable_d == DEB_FRAMES) && (stable_q != DEB_FRAMES);
    end

    // Frame load, debounce evaluation and event registration pipeline.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            frame_q     <= 16'd0;
            eval_q      <= 1'b0;
            prev_q      <= 16'd0;
            stable_q    <= 4'd0;
            deb_q       <= 16'd0;
            deb_old_q   <= 16'd0;
            upd_q       <= 1'b0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            eval_q <= frame_ld_q;
            if (frame_ld_q) begin
                frame_q <= snap_q;
            end
            upd_q <= eval_q && accept_s;
            if (eval_q) begin
                stable_q <= stable_d;
                prev_q   <= frame_q;
                if (accept_s) begin
                    deb_q     <= frame_q;
                    deb_old_q <= deb_q;
                end
            end
            // A press is reported only when coming from a fully released pad.
            key_valid_q <= upd_q && (deb_old_q == 16'd0) && is_onehot(deb_q);
            if (upd_q && (deb_old_q == 16'd0) && is_onehot(deb_q)) begin
                key_code_q <= onehot_to_idx(deb_q);
            end
            key_down_q <= |deb_q;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
